bus_responder_v35: RTL

BUS_RESPONDER_V35 -- requirements
Module: bus_responder_v35

---
 rtl/bus_responder_v35.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_responder_v35.sv
// CPU strobe-cycle to single-request memory/IO bridge with wait-state insertion and a sticky protocol-error flag.
// Latency: request one clk after the strobe edge; ready follows mem_ack after MEM_WAIT/IO_WAIT ce_1 edges.
// Backpressure: mem_req and all mem_* outputs are held until mem_ack; the CPU is stalled by ready=0.
module bus_responder_v35 #(
   parameter int MEM_WAIT = 0,
   parameter int IO_WAIT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_1,
   input  logic        ce_2,
   input  logic        r_w,
   input  logic        n_ube,
   input  logic        n_mreq,
   input  logic        n_mstb,
   input  logic        n_iostb,
   input  logic [19:0] addr,
   input  logic [15:0] cpu_dout,
   output logic [15:0] cpu_din,
   output logic        ready,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic        mem_io,
   output logic        mem_we,
   output logic [18:0] mem_addr,
   output logic [1:0]  mem_be,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        bus_error
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam logic [3:0] MEM_WAIT_CNT = 4'(MEM_WAIT);
   localparam logic [3:0] IO_WAIT_CNT  = 4'(IO_WAIT);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        ready_nxt;
   logic        mem_req_nxt;
   logic        mem_io_nxt;
   logic        mem_we_nxt;
   logic [18:0] mem_addr_nxt;
   logic [1:0]  mem_be_nxt;
   logic [15:0] mem_wdata_nxt;
   logic [15:0] cpu_din_nxt;
   logic        bus_error_nxt;

   logic        mem_strb;
   logic        io_strb;
   logic        one_strb;
   logic        any_strb;
   logic        cyc_strb;
   logic [3:0]  ack_wait;
   logic        unused_ce_2;

   // ce_2 is part of the CPU phase interface but wait counting only needs ce_1.
   assign unused_ce_2 = ce_2;

   assign mem_strb = ~n_mstb;
   assign io_strb  = ~n_iostb;
   assign one_strb = mem_strb ^ io_strb;
   assign any_strb = mem_strb | io_strb;
   // Strobe belonging to the cycle in flight; its release mid-cycle is the violation.
   assign cyc_strb = mem_io ? io_strb : mem_strb;
   assign ack_wait = mem_io ? IO_WAIT_CNT : MEM_WAIT_CNT;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      ready_nxt     = ready;
      mem_req_nxt   = mem_req;
      mem_io_nxt    = mem_io;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_be_nxt    = mem_be;
      mem_wdata_nxt = mem_wdata;
      cpu_din_nxt   = cpu_din;
      bus_error_nxt = bus_error;

      case (state)
         IDLE: begin
            if (one_strb && !n_mreq) begin
               mem_io_nxt    = io_strb;
               mem_we_nxt    = ~r_w;
               mem_addr_nxt  = addr[19:1];
               mem_be_nxt    = {~n_ube, ~addr[0]};
               mem_wdata_nxt = cpu_dout;
               mem_req_nxt   = 1'b1;
               ready_nxt     = 1'b0;
               state_nxt     = REQ;
            end else if (any_strb) begin
               bus_error_nxt = 1'b1;
            end
         end

         REQ: begin
            if (mem_ack) begin
               mem_req_nxt = 1'b0;
               if (!mem_we) begin
                  cpu_din_nxt = mem_rdata;
               end
            end
            if (!cyc_strb) begin
               bus_error_nxt = 1'b1;
               if (mem_ack) begin
                  ready_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DRAIN;
               end
            end else if (mem_ack) begin
               if (ack_wait == 4'd0) begin
                  ready_nxt = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  cnt_nxt   = ack_wait;
                  state_nxt = WAIT;
               end
            end
         end

         WAIT: begin
            if (!cyc_strb) begin
               bus_error_nxt = 1'b1;
               cnt_nxt       = 4'd0;
               ready_nxt     = 1'b1;
               state_nxt     = IDLE;
            end else if (ce_1) begin
               if (cnt <= 4'd1) begin
                  cnt_nxt   = 4'd0;
                  ready_nxt = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
         end

         HOLD: begin
            if (!any_strb) begin
               state_nxt = IDLE;
            end
         end

         DRAIN: begin
            if (mem_ack) begin
               mem_req_nxt = 1'b0;
               ready_nxt   = 1'b1;
               state_nxt   = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         ready     <= 1'b1;
         mem_req   <= 1'b0;
         mem_io    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 19'd0;
         mem_be    <= 2'b00;
         mem_wdata <= 16'h0000;
         cpu_din   <= 16'h0000;
         bus_error <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ready     <= ready_nxt;
         mem_req   <= mem_req_nxt;
         mem_io    <= mem_io_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_be    <= mem_be_nxt;
         mem_wdata <= mem_wdata_nxt;
         cpu_din   <= cpu_din_nxt;
         bus_error <= bus_error_nxt;
      end
   end

   // A pending request must present a frozen address/control set to the downstream side.
   a_req_stable: assert property (@(posedge clk) disable iff (reset)
      (mem_req && !mem_ack) |=> ($stable(mem_addr) && $stable(mem_be) && $stable(mem_we)
                                 && $stable(mem_io) && $stable(mem_wdata)));

   a_req_not_ready: assert property (@(posedge clk) disable iff (reset)
      mem_req |-> !ready);

endmodule
